// File: rtl/autocorr_counter.sv
// autocorr_counter: sliding-window autocorrelator for a serial bit stream.
// Counts how many of the newest WIN samples equal the sample lag_q positions
// older, and publishes that count (registered) with a one-cycle valid pulse.
// The FSM waits until the history holds WIN+lag_q fresh samples before it
// starts producing results.
module autocorr_counter #(
    parameter int WIN     = 3,
    parameter int LAG_MAX = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bit_in,
    input  logic       bit_valid,
    input  logic [1:0] lag,
    input  logic       clear,
    output logic [1:0] count,
    output logic       count_valid,
    output logic       running
);

    localparam int DEPTH = WIN + LAG_MAX;
    localparam int FW    = $clog2(DEPTH + 1);
    localparam logic [1:0] LAG_MAX_L = 2'(LAG_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    // Number of positions i in 0..WIN-1 where h[i] == h[i+lg].
    // lg never exceeds LAG_MAX, so i+lg always stays inside the history.
    function automatic logic [1:0] match_count(input logic [DEPTH-1:0] h,
                                               input logic [1:0]       lg);
        logic [WIN-1:0] eq;
        logic [1:0]     cnt;
        eq  = WIN'(~(h ^ (h >> lg)));
        cnt = 2'd0;
        for (int i = 0; i < WIN; i++) begin
            cnt = cnt + {1'b0, eq[i]};
        end
        return cnt;
    endfunction

    // The oldest history slot is only ever read right after a shift, so it
    // exists solely in the combinational post-shift vector hist_shift_s.
    state_t             state_q, state_d;
    logic [DEPTH-2:0]   hist_q, hist_d;
    logic [FW-1:0]      fill_q, fill_d;
    logic [1:0]         lag_q, lag_d;
    logic [1:0]         count_q, count_d;
    logic               count_valid_q, count_valid_d;
    logic               running_q, running_d;

    logic [DEPTH-1:0]   hist_shift_s;
    logic [1:0]         lag_eff_s;
    logic [FW-1:0]      fill_inc_s;
    logic [FW-1:0]      fill_target_s;

    // Map the lag input into the legal 1..LAG_MAX range.
    always_comb begin
        lag_eff_s = lag;
        if (lag == 2'd0) begin
            lag_eff_s = 2'd1;
        end else if (lag > LAG_MAX_L) begin
            lag_eff_s = LAG_MAX_L;
        end else begin
            lag_eff_s = lag;
        end
    end

    assign hist_shift_s  = {hist_q, bit_in};
    assign fill_inc_s    = fill_q + FW'(1);
    assign fill_target_s = FW'(WIN) + FW'(lag_q);

    // Next-state logic: clear first, then lag change, then sample acceptance.
    always_comb begin
        state_d       = state_q;
        hist_d        = hist_q;
        fill_d        = fill_q;
        lag_d         = lag_q;
        count_d       = count_q;
        count_valid_d = 1'b0;

        if (clear) begin
            hist_d  = '0;
            fill_d  = '0;
            state_d = IDLE;
            count_d = 2'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bit_valid) begin
                        hist_d = hist_shift_s[DEPTH-2:0];
                        lag_d  = lag_eff_s;
                        fill_d = FW'(1);
                        if ((FW'(WIN) + FW'(lag_eff_s)) == FW'(1)) begin
                            state_d = RUN;
                        end else begin
                            state_d = FILL;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                FILL, RUN: begin
                    if (lag_eff_s != lag_q) begin
                        // New lag invalidates the fill; history is kept.
                        lag_d   = lag_eff_s;
                        state_d = FILL;
                        if (bit_valid) begin
                            hist_d = hist_shift_s[DEPTH-2:0];
                            fill_d = FW'(1);
                        end else begin
                            fill_d = '0;
                        end
                    end else if (bit_valid) begin
                        hist_d = hist_shift_s[DEPTH-2:0];
                        if (state_q == RUN) begin
                            count_d       = match_count(hist_shift_s, lag_q);
                            count_valid_d = 1'b1;
                        end else begin
                            fill_d = fill_inc_s;
                            if (fill_inc_s == fill_target_s) begin
                                state_d       = RUN;
                                count_d       = match_count(hist_shift_s, lag_q);
                                count_valid_d = 1'b1;
                            end else begin
                                state_d = FILL;
                            end
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                default: begin
                    state_d = IDLE;
                    hist_d  = '0;
                    fill_d  = '0;
                    count_d = 2'd0;
                end
            endcase
        end
        running_d = (state_d == RUN);
    end

    // State, history and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            hist_q        <= '0;
            fill_q        <= '0;
            lag_q         <= 2'd1;
            count_q       <= 2'd0;
            count_valid_q <= 1'b0;
            running_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            hist_q        <= hist_d;
            fill_q        <= fill_d;
            lag_q         <= lag_d;
            count_q       <= count_d;
            count_valid_q <= count_valid_d;
            running_q     <= running_d;
        end
    end

    assign count       = count_q;
    assign count_valid = count_valid_q;
    assign running     = running_q;

endmodule
